// File: rtl/complex_div_pkg.sv
// complex_pkg: shared widths, FSM state type and signed saturation for complex_div.
package complex_pkg;
  localparam int A_W = 16;
  localparam int B_W = 8;
  localparam int DIV_W = A_W + B_W + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  // Returns {ovf, q}: applies the sign to a magnitude and clips to the B_W signed range.
  function automatic logic [B_W:0] sat_b_w(input logic neg, input logic [DIV_W-1:0] mag);
    logic [DIV_W-1:0] lim, m;
    lim = DIV_W'(neg) + DIV_W'(2 ** (B_W - 1) - 1);
    m = mag > lim ? lim : mag;
    m = neg ? -m : m;
    return {mag > lim, m[B_W-1:0]};
  endfunction
endpackage

// File: rtl/complex_div_serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle, MSB first.
module serial_divider #(
  parameter int N_W = 25,
  parameter int D_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quotient,
  output logic           done
);
  localparam int C_W = $clog2(N_W + 1);
  logic [D_W-1:0] rem, div_r;
  logic [C_W-1:0] cnt;
  logic [D_W:0] trial, diff;
  logic ge;
  always_comb begin
    trial = {rem, quotient[N_W-1]};
    diff = trial - {1'b0, div_r};
    ge = trial >= {1'b0, div_r};
  end
  assign done = cnt == '0;
  // Dividend bits shift out of quotient as result bits shift in.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      div_r <= '0;
      quotient <= '0;
    end else if (start) begin
      cnt <= C_W'(N_W);
      rem <= '0;
      div_r <= divisor;
      quotient <= dividend;
    end else if (!done) begin
      cnt <= cnt - 1'b1;
      rem <= ge ? diff[D_W-1:0] : trial[D_W-1:0];
      quotient <= {quotient[N_W-2:0], ge};
    end
  end
endmodule

// File: rtl/complex_div.sv
// complex_div: sequential complex divider q = z*conj(b)/|b|^2; COMPLEX_DIV_ROUND_EN selects round-to-nearest.
module complex_div import complex_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic signed [A_W-1:0] z_real,
  input  logic signed [A_W-1:0] z_imag,
  input  logic signed [B_W-1:0] b_real,
  input  logic signed [B_W-1:0] b_imag,
  output logic                  ready,
  output logic signed [B_W-1:0] q_real,
  output logic signed [B_W-1:0] q_imag,
  output logic                  q_valid,
  output logic                  q_ovf,
  output logic                  q_dz
);
  state_t state;
  logic signed [A_W-1:0] zr, zi;
  logic signed [B_W-1:0] br, bi;
  logic signed [DIV_W-1:0] nr, ni;
  logic [2*B_W-1:0] den;
  logic [DIV_W-1:0] mr, mi, qr_mag, qi_mag;
  logic [B_W:0] sr, si;
  logic nr_neg, ni_neg, dz, done_r, done_i, accept;
  assign accept = data_valid && ready;
  always_comb begin
    nr = DIV_W'(zr) * DIV_W'(br) + DIV_W'(zi) * DIV_W'(bi);
    ni = DIV_W'(zi) * DIV_W'(br) - DIV_W'(zr) * DIV_W'(bi);
    den = (2*B_W)'(br) * (2*B_W)'(br) + (2*B_W)'(bi) * (2*B_W)'(bi);
    mr = nr[DIV_W-1] ? -nr : nr;
    mi = ni[DIV_W-1] ? -ni : ni;
`ifdef COMPLEX_DIV_ROUND_EN
    mr = mr + DIV_W'(den >> 1);
    mi = mi + DIV_W'(den >> 1);
`endif
  end
  serial_divider #(.N_W(DIV_W), .D_W(2*B_W)) u_div_r (
    .clk(clk), .rst(rst), .start(state == LOAD), .dividend(mr), .divisor(den),
    .quotient(qr_mag), .done(done_r)
  );
  serial_divider #(.N_W(DIV_W), .D_W(2*B_W)) u_div_i (
    .clk(clk), .rst(rst), .start(state == LOAD), .dividend(mi), .divisor(den),
    .quotient(qi_mag), .done(done_i)
  );
  assign sr = sat_b_w(nr_neg, qr_mag);
  assign si = sat_b_w(ni_neg, qi_mag);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      q_valid <= 1'b0;
      q_real <= '0;
      q_imag <= '0;
      q_ovf <= 1'b0;
      q_dz <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      if (accept) begin
        zr <= z_real;
        zi <= z_imag;
        br <= b_real;
        bi <= b_imag;
      end
      case (state)
        IDLE: begin
          state <= accept ? LOAD : IDLE;
          ready <= !accept;
        end
        LOAD: begin
          state <= DIV;
          nr_neg <= nr[DIV_W-1];
          ni_neg <= ni[DIV_W-1];
          dz <= den == '0;
        end
        DIV: if (done_r && done_i) begin
          state <= DONE;
          ready <= 1'b1;
          q_valid <= 1'b1;
          q_real <= dz ? '0 : sr[B_W-1:0];
          q_imag <= dz ? '0 : si[B_W-1:0];
          q_ovf <= !dz && (sr[B_W] || si[B_W]);
          q_dz <= dz;
        end
        DONE: begin
          state <= accept ? LOAD : IDLE;
          ready <= !accept;
        end
      endcase
    end
  end
endmodule
